// File: rtl/store_buffer_fwd_pkg.sv
// Shared definitions for the forwarding store buffer: entry states, store/load
// size encodings and the byte-lane mask helper used at execute and at lookup.
package store_buffer_fwd_pkg;

  typedef enum logic [1:0] {
    SB_FREE   = 2'd0,
    SB_ALLOC  = 2'd1,
    SB_EXEC   = 2'd2,
    SB_COMMIT = 2'd3
  } sb_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // Byte-lane mask for an access of 'size' at byte 'offset' within an XLEN word.
  // A doubleword on a 32-bit machine degrades to a word. Callers keep the low
  // XLEN/8 bits.
  function automatic logic [7:0] byte_mask(input logic [1:0] size,
                                           input logic [2:0] offset,
                                           input int xlen);
    logic [7:0] base;
    case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0F;
      default: base = (xlen == 64) ? 8'hFF : 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_forward_select.sv
// Store-to-load forwarding search. Walks the candidate window from the oldest
// entry (head) to the entry just before the load's recorded tail; the youngest
// overlapping store decides hit versus partial-overlap stall, and any store in
// the window that still lacks its address forces a stall.
module sb_forward_select
  import store_buffer_fwd_pkg::*;
#(
  parameter int SB_INDEX_WIDTH = 3,
  parameter int XLEN           = 32
) (
  input  sb_state_e                 state        [2**SB_INDEX_WIDTH],
  input  logic [XLEN-1:0]           address      [2**SB_INDEX_WIDTH],
  input  logic [XLEN-1:0]           value        [2**SB_INDEX_WIDTH],
  input  logic [XLEN/8-1:0]         byte_en      [2**SB_INDEX_WIDTH],
  input  logic [SB_INDEX_WIDTH-1:0] head_idx,
  input  logic                      load_valid,
  input  logic [SB_INDEX_WIDTH-1:0] load_SB_tail,
  input  logic [XLEN-1:0]           load_address,
  input  logic [1:0]                load_size,
  output logic                      hit,
  output logic                      stall,
  output logic [XLEN-1:0]           data
);

  localparam int DEPTH = 2**SB_INDEX_WIDTH;
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [XLEN-1:0] WORD_MASK = ~((XLEN)'(BE_W - 1));

  logic [SB_INDEX_WIDTH-1:0] count;
  logic [SB_INDEX_WIDTH-1:0] idx;
  logic [7:0]                load_mask8;
  logic [BE_W-1:0]           load_mask;
  logic                      any_alloc;
  logic                      found;
  logic                      covers;
  logic [XLEN-1:0]           fwd_value;

  assign load_mask8 = byte_mask(load_size, 3'(load_address[OFF_W-1:0]), XLEN);
  assign load_mask  = load_mask8[BE_W-1:0];

  // Oldest-to-youngest scan; later matches overwrite earlier ones so the
  // youngest overlapping store wins.
  always_comb begin
    count     = load_SB_tail - head_idx;
    idx       = head_idx;
    any_alloc = 1'b0;
    found     = 1'b0;
    covers    = 1'b0;
    fwd_value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + SB_INDEX_WIDTH'(i);
      if (SB_INDEX_WIDTH'(i) < count) begin
        if (state[idx] == SB_ALLOC) begin
          any_alloc = 1'b1;
        end else if (state[idx] != SB_FREE &&
                     ((address[idx] ^ load_address) & WORD_MASK) == '0 &&
                     (byte_en[idx] & load_mask) != '0) begin
          found     = 1'b1;
          covers    = ((byte_en[idx] & load_mask) == load_mask);
          fwd_value = value[idx];
        end
      end
    end
  end

  // Resolve the scan into the three outputs, all quiet without a lookup.
  always_comb begin
    hit   = 1'b0;
    stall = 1'b0;
    data  = '0;
    if (load_valid) begin
      if (any_alloc) begin
        stall = 1'b1;
      end else if (found) begin
        if (covers) begin
          hit  = 1'b1;
          data = fwd_value;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer_fwd.sv
// In-order-drain store buffer with flush of uncommitted entries and a
// store-to-load forwarding port. Entries move FREE -> ALLOC (issue) -> EXEC
// (address/data known) -> COMMIT (retired by the ROB) -> FREE (written to
// memory). Three pointers with a wrap bit track drain (head), oldest
// uncommitted (cmt) and allocation (tail).
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high; ready never depends on the same-cycle valid, and flush
// cancels any issue/execute/commit transfer in its cycle.
module store_buffer_fwd
  import store_buffer_fwd_pkg::*;
#(
  parameter int SB_INDEX_WIDTH      = 3,
  parameter int XLEN                = 32,
  parameter int DECODED_INSTR_WIDTH = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           issue_SB_valid,
  output logic                           issue_SB_ready,
  input  logic [XLEN-1:0]                issue_SB_PC,
  input  logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction,
  output logic [SB_INDEX_WIDTH-1:0]      issue_SB_tail,
  input  logic                           execute_valid,
  output logic                           execute_ready,
  input  logic [SB_INDEX_WIDTH-1:0]      execute_SB_tail,
  input  logic [XLEN-1:0]                execute_address,
  input  logic [XLEN-1:0]                execute_value,
  input  logic                           store_commit_valid,
  output logic                           store_commit_ready,
  output logic [XLEN-1:0]                store_commit_address,
  output logic                           store_request_valid,
  input  logic                           store_request_ready,
  output logic [XLEN-1:0]                store_request_address,
  output logic [XLEN-1:0]                store_request_value,
  output logic [XLEN/8-1:0]              store_request_byte_en,
  input  logic                           load_valid,
  input  logic [SB_INDEX_WIDTH-1:0]      load_SB_tail,
  input  logic [XLEN-1:0]                load_address,
  input  logic [1:0]                     load_size,
  output logic                           load_forward_hit,
  output logic [XLEN-1:0]                load_forward_data,
  output logic                           load_forward_stall
);

  localparam int DEPTH = 2**SB_INDEX_WIDTH;
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = SB_INDEX_WIDTH + 1;
  localparam logic [XLEN-1:0] WORD_MASK = ~((XLEN)'(BE_W - 1));

  sb_state_e       state_q   [DEPTH];
  logic [1:0]      size_q    [DEPTH];
  logic [XLEN-1:0] pc_q      [DEPTH];
  logic [XLEN-1:0] address_q [DEPTH];
  logic [XLEN-1:0] value_q   [DEPTH];
  logic [BE_W-1:0] byte_en_q [DEPTH];

  logic [PTR_W-1:0] head_q, cmt_q, tail_q;
  logic [SB_INDEX_WIDTH-1:0] head_idx, cmt_idx, tail_idx;
  logic full;
  logic issue_fire, exec_fire, commit_fire, drain_fire;
  logic [7:0]      exec_mask8;
  logic [XLEN-1:0] exec_value;
  logic            unused_debug;

  assign head_idx = head_q[SB_INDEX_WIDTH-1:0];
  assign cmt_idx  = cmt_q[SB_INDEX_WIDTH-1:0];
  assign tail_idx = tail_q[SB_INDEX_WIDTH-1:0];
  assign full     = (head_q[SB_INDEX_WIDTH] != tail_q[SB_INDEX_WIDTH]) && (head_idx == tail_idx);

  assign issue_SB_ready        = !full;
  assign issue_SB_tail         = tail_idx;
  assign execute_ready         = 1'b1;
  assign store_commit_ready    = (state_q[cmt_idx] == SB_EXEC) && (cmt_q != tail_q);
  assign store_commit_address  = address_q[cmt_idx];
  assign store_request_valid   = (state_q[head_idx] == SB_COMMIT);
  assign store_request_address = address_q[head_idx] & WORD_MASK;
  assign store_request_value   = value_q[head_idx];
  assign store_request_byte_en = byte_en_q[head_idx];

  assign issue_fire  = issue_SB_valid && issue_SB_ready && !flush;
  assign exec_fire   = execute_valid && !flush && (state_q[execute_SB_tail] == SB_ALLOC);
  assign commit_fire = store_commit_valid && store_commit_ready && !flush;
  assign drain_fire  = store_request_valid && store_request_ready;

  // Lane alignment happens once, at execute, so drain and forwarding see
  // memory-ready data and masks.
  assign exec_mask8 = byte_mask(size_q[execute_SB_tail], 3'(execute_address[OFF_W-1:0]), XLEN);
  assign exec_value = execute_value << {execute_address[OFF_W-1:0], 3'b000};

  // The stored PC and the non-size opcode bits are kept for debug visibility only.
  always_comb begin
    unused_debug = ^issue_decoded_instruction[DECODED_INSTR_WIDTH-1:2];
    for (int i = 0; i < DEPTH; i++) begin
      unused_debug = unused_debug ^ (^pc_q[i]);
    end
  end

  // Entry array and pointer update; flush discards uncommitted work and
  // rewinds tail to the commit pointer while committed entries keep draining.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]   <= SB_FREE;
        size_q[i]    <= SIZE_B;
        pc_q[i]      <= '0;
        address_q[i] <= '0;
        value_q[i]   <= '0;
        byte_en_q[i] <= '0;
      end
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      if (issue_fire) begin
        state_q[tail_idx] <= SB_ALLOC;
        size_q[tail_idx]  <= issue_decoded_instruction[1:0];
        pc_q[tail_idx]    <= issue_SB_PC;
      end
      if (exec_fire) begin
        state_q[execute_SB_tail]   <= SB_EXEC;
        address_q[execute_SB_tail] <= execute_address;
        value_q[execute_SB_tail]   <= exec_value;
        byte_en_q[execute_SB_tail] <= exec_mask8[BE_W-1:0];
      end
      if (commit_fire) begin
        state_q[cmt_idx] <= SB_COMMIT;
        cmt_q            <= cmt_q + 1'b1;
      end
      if (drain_fire) begin
        state_q[head_idx] <= SB_FREE;
        head_q            <= head_q + 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (state_q[i] == SB_ALLOC || state_q[i] == SB_EXEC) begin
            state_q[i] <= SB_FREE;
          end
        end
        tail_q <= cmt_q;
      end else if (issue_fire) begin
        tail_q <= tail_q + 1'b1;
      end
    end
  end

  sb_forward_select #(
    .SB_INDEX_WIDTH(SB_INDEX_WIDTH),
    .XLEN          (XLEN)
  ) u_forward_select (
    .state       (state_q),
    .address     (address_q),
    .value       (value_q),
    .byte_en     (byte_en_q),
    .head_idx    (head_idx),
    .load_valid  (load_valid),
    .load_SB_tail(load_SB_tail),
    .load_address(load_address),
    .load_size   (load_size),
    .hit         (load_forward_hit),
    .stall       (load_forward_stall),
    .data        (load_forward_data)
  );

endmodule

// File: doc/store_buffer_fwd.md
# store_buffer_fwd

Parametrised, in-order-drain store buffer for the out-of-order core. Sits between the store issue queue, the store AGU/execute stage, the ROB commit port and the data memory. It adds three things over the first-generation store buffer: configurable XLEN (32/64) and depth, flush of uncommitted entries only, and a store-to-load forwarding port for the load unit. Committed stores drain to memory in program order.

## Interface
- SB_INDEX_WIDTH, 3, log2 of entry count (depth = 2^SB_INDEX_WIDTH)
- XLEN, 32, data/address width; 32 or 64
- DECODED_INSTR_WIDTH, 6, decoded store op width; bits [1:0] give size
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- flush  in  1  discard all uncommitted entries
- issue_SB_valid  in  1  allocate entry
- issue_SB_ready  out  1  entry available
- issue_SB_PC  in  XLEN  store PC (kept for debug)
- issue_decoded_instruction  in  DECODED_INSTR_WIDTH  store op
- issue_SB_tail  out  SB_INDEX_WIDTH  index the next allocation receives
- execute_valid  in  1  address/data ready
- execute_ready  out  1  tied 1
- execute_SB_tail  in  SB_INDEX_WIDTH  target entry
- execute_address, execute_value  in  XLEN  store address and unshifted data
- store_commit_valid  in  1  ROB head is a store
- store_commit_ready  out  1  oldest uncommitted entry is executed
- store_commit_address  out  XLEN  address of that entry
- store_request_valid  out  1  head entry committed
- store_request_ready  in  1  memory accepts
- store_request_address  out  XLEN  word-aligned address
- store_request_value  out  XLEN  lane-aligned data
- store_request_byte_en  out  XLEN/8  byte mask
- load_valid  in  1  forwarding lookup
- load_SB_tail  in  SB_INDEX_WIDTH  issue_SB_tail sampled when the load was issued
- load_address  in  XLEN  load address
- load_size  in  2  00 B, 01 H, 10 W, 11 D
- load_forward_hit  out  1  full data forwarded
- load_forward_data  out  XLEN  lane-aligned forwarded data
- load_forward_stall  out  1  load must retry

## Operation
- Entry states: FREE, ALLOC, EXEC, COMMIT. Pointers: head (drain), cmt (oldest non-committed), tail. Each pointer has an extra wrap bit; full = tails equal except wrap bit; empty = all bits equal.
- Size encoding: 00 SB, 01 SH, 10 SW, 11 SD. SD with XLEN=32 is treated as SW.
- Byte offset field = address[log2(XLEN/8)-1:0]. byte_en = size mask << offset. Value is shifted left by 8·offset. Both are computed at execute and stored.
- Issue: on valid & ready, entry[tail] goes ALLOC and stores size/PC; tail++. issue_SB_ready = !full.
- Execute: writes address, value and byte_en and moves the entry ALLOC→EXEC. A write to an entry not in ALLOC is ignored.
- Commit: store_commit_ready = (entry[cmt] == EXEC) and cmt != tail. On valid & ready the entry goes COMMIT and cmt++.
- Drain: store_request_valid = (entry[head] == COMMIT). On valid & ready the entry goes FREE and head++.
- Flush: every ALLOC/EXEC entry goes FREE and tail ← cmt. COMMIT entries keep draining.
- Forwarding (combinational):
  - Candidates are entries from head up to load_SB_tail (exclusive).
  - Any candidate in ALLOC → stall=1.
  - Otherwise take the youngest candidate whose word address matches and whose byte_en overlaps the load mask:
    - if it covers all load bytes → hit=1, data = its value;
    - if it covers only some → stall=1;
    - if there is no such candidate → hit=0, stall=0.
  - All forwarding outputs are 0 when load_valid=0.

## Timing
- Reset values:
  - all entries FREE; head = cmt = tail = 0;
  - issue_SB_ready = 1, execute_ready = 1;
  - store_commit_ready = 0, store_request_valid = 0;
  - load_forward_hit = 0, load_forward_stall = 0;
  - data outputs 0.
- Latencies:
  - issue: entry visible the next cycle;
  - execute → commit-eligible: 1 cycle;
  - commit → store_request_valid: 1 cycle;
  - drain outputs are driven combinationally from head registers.
- Forwarding is same-cycle and uses registered state only. A store executing in the same cycle as a lookup is not seen; its entry is still ALLOC, so the load stalls.
- Full with a drain in the same cycle: issue is still refused, because ready comes from registered full.
- Flush in the same cycle as issue, execute or commit of an uncommitted entry: flush wins and that operation is dropped.
- Wrap-around: index = pointer bits [SB_INDEX_WIDTH-1:0]; pointers wrap naturally.

## Structure
- Shared package holds:
  - entry state encoding (FREE/ALLOC/EXEC/COMMIT);
  - size encoding constants;
  - a byte-mask function (size, offset, XLEN).
- One sub-module, sb_forward_select: a priority search over the entry array returning hit/stall/data. It is parametrised like the parent.

## Test plan
- Reset, then idle → issue_SB_ready=1, execute_ready=1, store_request_valid=0, load_forward_hit=0.
- Issue 8 stores → 9th issue refused. Execute entries 0, 3, 1, then 2 with addresses 10000+4i; commit all. Drain with ready=1 → 4 requests in order, byte_en=4'hF. Tail wraps to 0 and issue is accepted again.
- SB to 0x1003, value 0xAB → byte_en=4'b1000, value=0xAB000000. SH to 0x1002 → byte_en=4'b1100.
- Two SWs to 0x2000 (0x11111111, then 0x22222222), then a LW 0x2000 → hit=1, data=0x22222222. LH 0x2002 after only an SB 0x2002 → stall=1. An older store still in ALLOC → stall=1.
- 2 stores committed, 3 executed, flush → tail=2, the 2 committed entries still drain, and store_commit_ready=0.
- Drive reset=0 mid-drain with store_request_valid=1 → outputs return to reset values immediately, without waiting for a clock.
